// File: rtl/demux7_1_collect.sv
// demux7_1_collect -- registered 1-to-7 demultiplexing collector.
//
// Items arrive one per in_valid/in_ready handshake. Each item is written to
// the lane chosen by sel. Once all seven lanes have been written, the
// assembled frame is presented on out_data with out_valid. The frame is held
// until out_ready is asserted.
//
// Optional build macro: DEMUX7_AUTO_SEL_EN
//   When defined, sel is ignored and an internal pointer fills lanes in the
//   order 0..6. In this mode sel_err is always 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     producer has an item
//   in_data[W]   item to steer
//   sel[3]       destination lane 0..6 (7 is illegal)
//   in_ready     block accepts an item this cycle
//   out_data[7W] assembled frame, lane i at [i*W +: W]
//   out_valid    frame complete and stable
//   out_ready    consumer takes the frame
//   lane_written bit i = lane i written in the current frame
//   sel_err      one-cycle pulse after an accepted item with sel==7

module demux7_1_collect_lane #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (we)    q <= d;
  end
endmodule

module demux7_1_collect #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic [2:0]     sel,
  output logic           in_ready,
  output logic [7*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [6:0]     lane_written,
  output logic           sel_err
);
  typedef enum logic {COLLECT, HOLD} state_t;

  state_t              state, state_nxt;
  logic                accept, release_frame, err_nxt;
  logic [2:0]          dest;
  logic [6:0]          wr_lane, written_nxt;
  logic [6:0][W-1:0]   lane_q;

  assign in_ready      = !rst && (state == COLLECT);
  assign accept        = in_valid && in_ready;
  assign release_frame = (state == HOLD) && out_ready;
  assign out_valid     = (state == HOLD);
  assign out_data      = lane_q;

`ifdef DEMUX7_AUTO_SEL_EN
  logic [2:0] ptr;
  logic       unused_sel;
  assign unused_sel = ^sel;
  assign dest       = ptr;
  assign err_nxt    = 1'b0;

  always_ff @(posedge clk) begin
    if (rst)                ptr <= 3'd0;
    else if (release_frame) ptr <= 3'd0;
    else if (accept)        ptr <= (ptr == 3'd6) ? 3'd0 : ptr + 3'd1;
  end
`else
  assign dest    = sel;
  assign err_nxt = accept && (sel == 3'd7);
`endif

  // A shift by 7 pushes the bit out of the 7-bit vector, so sel==7 writes
  // no lane without needing a separate guard.
  always_comb begin
    wr_lane     = accept ? (7'h01 << dest) : 7'h00;
    written_nxt = lane_written | wr_lane;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && written_nxt == 7'h7F) state_nxt = HOLD;
      HOLD:    if (out_ready)                      state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      lane_written <= 7'h00;
      sel_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel_err      <= err_nxt;
      lane_written <= release_frame ? 7'h00 : written_nxt;
    end
  end

  for (genvar i = 0; i < 7; i++) begin : g_lane
    demux7_1_collect_lane #(.W(W)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (release_frame),
      .we  (wr_lane[i]),
      .d   (in_data),
      .q   (lane_q[i])
    );
  end
endmodule
